// File: rtl/mem_burst_controller.sv
// mem_burst_controller
//   Request sequencer in front of the MxN memory block. Single and burst read/write
//   requests arrive over a valid/ready bus; the controller drives registered
//   Addr/WE/DataIn into the memory and returns read beats from its registered Dout
//   with RdValid/RdLast.
//
//   Build option: define MEM_WRAP_BURST_EN to make the burst address wrap inside the
//   aligned 2^BURST_WIDTH block holding ReqAddr (critical-word-first). Without it the
//   address increments linearly modulo 2^ADDR_WIDTH.
module mem_burst_controller #(
  parameter int unsigned MEM_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned BURST_WIDTH  = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [ADDR_WIDTH-1:0]  ReqAddr,
  input  logic [BURST_WIDTH-1:0] ReqLen,
  input  logic [MEM_WIDTH-1:0]   WrData,
  input  logic                   WrValid,
  output logic                   WrReady,
  output logic [MEM_WIDTH-1:0]   RdData,
  output logic                   RdValid,
  output logic                   RdLast,
  output logic                   Busy,
  output logic [ADDR_WIDTH-1:0]  MemAddr,
  output logic                   MemWE,
  output logic [MEM_WIDTH-1:0]   MemDataIn,
  input  logic [MEM_WIDTH-1:0]   MemDout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

`ifdef MEM_WRAP_BURST_EN
  // Low address bits that cycle inside one burst block; the rest stay fixed.
  localparam logic [ADDR_WIDTH-1:0] WRAP_MASK =
    ADDR_WIDTH'((64'd1 << BURST_WIDTH) - 64'd1);
`endif

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  addr_q;      // next address to present to the memory
  logic [BURST_WIDTH-1:0] cnt_q;       // beats still to issue (write: minus one)
  logic                   req_accept;
  logic                   rd_issue;
  logic                   rd_issue_last;
  logic [READ_LATENCY:0]  pipe_vld;    // tracks issued read beats until capture
  logic [READ_LATENCY:0]  pipe_last;
  logic                   ret_vld;
  logic                   ret_last;

  // Successor address. Wrapping keeps the upper bits of the current address, which
  // are always those of the start address, so no separate base register is needed.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] inc;
    inc = a + ADDR_WIDTH'(1);
`ifdef MEM_WRAP_BURST_EN
    return (a & ~WRAP_MASK) | (inc & WRAP_MASK);
`else
    return inc;
`endif
  endfunction

  assign ReqReady = (state == ST_IDLE);
  assign WrReady  = (state == ST_WRITE);
  assign Busy     = (state != ST_IDLE);
  assign ret_vld  = pipe_vld[READ_LATENCY];
  assign ret_last = pipe_last[READ_LATENCY];

  // Request handshake and read-beat issue decode for the current cycle.
  always_comb begin
    req_accept    = ReqValid && (state == ST_IDLE);
    rd_issue      = (req_accept && !ReqWrite) || (state == ST_READ);
    rd_issue_last = 1'b0;
    if (state == ST_IDLE) begin
      rd_issue_last = (ReqLen == '0);
    end else begin
      rd_issue_last = (cnt_q == BURST_WIDTH'(1));
    end
  end

  // Sequencer state plus the registered memory-side strobes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      MemAddr   <= '0;
      MemWE     <= 1'b0;
      MemDataIn <= '0;
    end else begin
      MemWE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_accept) begin
            cnt_q <= ReqLen;
            if (ReqWrite) begin
              addr_q <= ReqAddr;
              state  <= ST_WRITE;
            end else begin
              // Read beat 0 goes out on the accepting edge itself.
              MemAddr <= ReqAddr;
              addr_q  <= next_addr(ReqAddr);
              state   <= (ReqLen == '0) ? ST_DRAIN : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (WrValid) begin
            MemWE     <= 1'b1;
            MemAddr   <= addr_q;
            MemDataIn <= WrData;
            addr_q    <= next_addr(addr_q);
            if (cnt_q == '0) begin
              state <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - BURST_WIDTH'(1);
            end
          end
        end
        ST_READ: begin
          MemAddr <= addr_q;
          addr_q  <= next_addr(addr_q);
          cnt_q   <= cnt_q - BURST_WIDTH'(1);
          if (cnt_q == BURST_WIDTH'(1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave on the edge that presents the final beat to the bus.
          if (ret_vld && ret_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read return path: issued beats age through the pipe until memory data is captured.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      RdValid   <= 1'b0;
      RdLast    <= 1'b0;
      RdData    <= '0;
    end else begin
      pipe_vld  <= {pipe_vld[READ_LATENCY-1:0], rd_issue};
      pipe_last <= {pipe_last[READ_LATENCY-1:0], rd_issue && rd_issue_last};
      RdValid   <= ret_vld;
      RdLast    <= ret_vld && ret_last;
      if (ret_vld) begin
        RdData <= MemDout;
      end
    end
  end

endmodule
